// File: rtl/muldiv_issue_sched.sv
// Issue scheduler for the shared, non-pipelined multiply/divide unit.
// Round-robin grant, op-dependent latency timing, and result hold until the CDB accepts it.
//
// state    | meaning
// IDLE     | unit free, waiting for a request
// EXEC     | op in flight, latency counter running
// WAIT_CDB | result held, broadcasting until cdb_gnt_i
module muldiv_issue_sched #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 64,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        div_i,
  input  logic [NUM_REQ*TAG_W-1:0]  tag_i,
  input  logic [NUM_REQ*DATA_W-1:0] opa_i,
  input  logic [NUM_REQ*DATA_W-1:0] opb_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      unit_start_o,
  output logic                      unit_mult_o,
  output logic                      unit_div_o,
  output logic [DATA_W-1:0]         unit_a_o,
  output logic [DATA_W-1:0]         unit_b_o,
  input  logic [DATA_W-1:0]         unit_result_i,
  output logic                      cdb_req_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  input  logic                      cdb_gnt_i,
  output logic                      busy_o
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, win;
  logic [CNT_W-1:0]   cnt_q;
  logic               win_vld, can_grant, grant;
  logic               div_q, start_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  a_q, b_q, res_q;

  // Downward scan so the requester closest to the pointer is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win     = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // rst_n gating keeps the combinational grant quiet while reset is held.
  always_comb begin
    can_grant = rst_n && !flush_i &&
                ((state_q == IDLE) || ((state_q == WAIT_CDB) && cdb_gnt_i));
    grant     = can_grant && win_vld;
    gnt_o     = '0;
    if (grant) gnt_o[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant) state_d = EXEC;
      EXEC:     if (cnt_q == CNT_W'(1)) state_d = WAIT_CDB;
      WAIT_CDB: if (cdb_gnt_i) state_d = grant ? EXEC : IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      start_q <= 1'b0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= grant;
      if (grant) begin
        ptr_q <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        div_q <= div_i[win];
        tag_q <= tag_i[int'(win)*TAG_W +: TAG_W];
        a_q   <= opa_i[int'(win)*DATA_W +: DATA_W];
        b_q   <= opb_i[int'(win)*DATA_W +: DATA_W];
        cnt_q <= div_i[win] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if ((state_q == EXEC) && (cnt_q == CNT_W'(1)) && !flush_i)
        res_q <= unit_result_i;
    end
  end

  assign unit_start_o = start_q;
  assign unit_mult_o  = (state_q == EXEC) && !div_q;
  assign unit_div_o   = (state_q == EXEC) && div_q;
  assign unit_a_o     = a_q;
  assign unit_b_o     = b_q;
  assign cdb_req_o    = (state_q == WAIT_CDB);
  assign cdb_tag_o    = tag_q;
  assign cdb_data_o   = res_q;
  assign busy_o       = (state_q != IDLE);

endmodule
